// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// State encoding, default width and counter sizing helper.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response handshake bundle for serial_add_ctrl.
// master = requester/consumer, slave = the adder block.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/full_adder.sv
// 1-bit full-adder cell.
// Port order: sum, carry-out, a, b, carry-in.
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, WIDTH cycles per operation,
// valid/ready request and response handshakes.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus,
  output logic              busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .s   (fa_s),
    .c   (fa_c),
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (c_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            c_q     <= bus.in_cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          c_q   <= fa_c;
          cnt_q <= cnt_q + CW'(1);
          // c_q here is the carry into the MSB cell
          if (cnt_q == LAST) begin
            cout_q  <= fa_c;
            ovf_q   <= c_q ^ fa_c;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port in_a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port in_b  input  WIDTH  operand B.
REQ-008 SHALL have port in_cin  input  1  carry-in to bit 0.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  WIDTH  sum, A+B+cin modulo 2^WIDTH.
REQ-012 SHALL have port out_cout  output  1  carry out of MSB.
REQ-013 SHALL have port out_ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-014 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; only IDLE->RUN, RUN->DONE, DONE->IDLE transitions exist.
REQ-016 IDLE: in_ready=1; in_valid&in_ready at an edge SHALL capture in_a, in_b into shift registers, in_cin into carry flop, clear bit counter, go RUN.
REQ-017 RUN: each cycle SHALL add LSBs of A and B with carry flop through one 1-bit full-adder cell, shift A/B right, shift sum bit into out_sum from MSB side, store cell carry-out into carry flop, increment counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; at edge where counter==WIDTH-1 SHALL go DONE.
REQ-019 SHALL record carry-in of MSB bit during last RUN cycle to form out_ovf.
REQ-020 Latency: out_valid SHALL rise in the cycle after the WIDTH-th edge following acceptance edge.
REQ-021 DONE: out_valid=1; out_sum, out_cout, out_ovf SHALL stay stable until out_valid&out_ready edge, then go IDLE.
REQ-022 No same-cycle accept on DONE->IDLE; minimum issue interval SHALL be WIDTH+2 cycles.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and operands not sampled.
REQ-024 out_sum/out_cout/out_ovf SHALL hold last result after handshake until next RUN modifies them; meaningful only with out_valid=1.
REQ-025 Arithmetic SHALL be exact for all inputs including all-ones operands with cin=1 (wrap to modulo result, cout=1).
REQ-026 in_ready and out_valid SHALL be decoded from registered state only (no combinational path from in_valid/out_ready).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, carry flop 0, shift registers 0.
REQ-028 During and after reset: in_ready=1 (once rst_n high), out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0.
REQ-029 Reset mid-RUN or mid-DONE SHALL discard the partial/pending result; no out_valid for that operation.

Structure
REQ-030 Shared package serial_add_pkg SHALL hold state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), default WIDTH constant, counter-width constant ($clog2(WIDTH)).
REQ-031 Sub-module: exactly one instance of the team's 1-bit full_adder cell (port order s, c, a, b, cin) as the bit-serial datapath; no other adder logic.

Verification (WIDTH=8)
REQ-032 0x0F+0x01, cin=0 -> out_sum=0x10, cout=0, ovf=0; out_valid in cycle after 8th edge post-accept.
REQ-033 0xFF+0x01, cin=0 -> out_sum=0x00, cout=1, ovf=0; 0x7F+0x01 -> 0x80, cout=0, ovf=1.
REQ-034 0x80+0x80, cin=1 -> out_sum=0x01, cout=1, ovf=1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, toggling in_valid with new operands has no effect; result returned after out_ready=1.
REQ-036 rst_n pulsed low after 3 RUN cycles -> out_valid stays 0, outputs all 0, in_ready=1 first cycle after release; next op 0x01+0x02 -> 0x03.
REQ-037 1000 random back-to-back ops with out_ready=1 -> all match golden A+B+cin model; issue interval exactly 10 cycles.
